// File: rtl/writeback_retire_pkg.sv
// writeback_retire_pkg: pipeline register, trace record and FSM types shared by the write-back stage
package writeback_retire_pkg;
  typedef logic [4:0] Vec5;
  typedef logic [31:0] Vec32;
  typedef Vec32 Instruction;
  typedef enum logic [3:0] {IC_NOP, IC_ALU, IC_LOAD, IC_STORE, IC_BRANCH, IC_SYSCALL} InstructionCode;
  localparam InstructionCode SYSCALL = IC_SYSCALL;
  typedef struct packed {
    InstructionCode instructionCode;
    logic           gprWriteEnabled;
  } ControlSignal;
  typedef struct packed {
    Vec32         pcValue;
    Instruction   instruction;
    ControlSignal controlSignal;
    Vec5          gprWriteRegister;
    Vec32         gprWriteInput;
  } MEM_WB_REG;
  // rd stands in for the register field; "reg" is a reserved word
  typedef struct packed {
    Vec32 pc;
    Vec5  rd;
    Vec32 data;
    Vec32 seq;
  } TraceEntry;
  typedef enum logic [1:0] {WB_RUN, WB_DRAIN, WB_HALTED} WbState;
  function automatic logic [5:0] ones(input logic [31:0] v);
    ones = '0;
    for (int i = 0; i < 32; i++) ones = ones + 6'(v[i]);
  endfunction
endpackage

// File: rtl/writeback_retire_trace_fifo.sv
// wb_trace_fifo: multi-enqueue, single-dequeue trace FIFO with occupancy output
// Enqueued lanes are packed into consecutive slots in lane order.
module wb_trace_fifo
  import writeback_retire_pkg::*;
#(
  parameter int LANES       = 2,
  parameter int TRACE_DEPTH = 8,
  localparam int AW         = $clog2(TRACE_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LANES-1:0]      enq_i,
  input  TraceEntry [LANES-1:0] enq_data_i,
  input  logic                  deq_i,
  output logic                  valid_o,
  output TraceEntry             head_o,
  output logic [AW:0]           occ_o
);
  TraceEntry     mem_q [TRACE_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   occ_q, n_enq;
  logic [AW-1:0] slot [LANES];
  logic          deq;
  always_comb begin
    n_enq = '0;
    for (int l = 0; l < LANES; l++) begin
      slot[l] = wr_ptr_q + n_enq[AW-1:0];
      n_enq = n_enq + (AW+1)'(enq_i[l]);
    end
  end
  assign deq     = deq_i && occ_q != '0;
  assign valid_o = occ_q != '0;
  assign head_o  = mem_q[rd_ptr_q];
  assign occ_o   = occ_q;
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++)
      if (enq_i[l]) mem_q[slot[l]] <= enq_data_i[l];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + n_enq[AW-1:0];
      rd_ptr_q <= rd_ptr_q + AW'(deq);
      occ_q    <= occ_q + n_enq - (AW+1)'(deq);
    end
  end
endmodule

// File: rtl/writeback_retire.sv
// writeback_retire: multi-lane retire stage with GPR write ports, commit trace FIFO and SYSCALL halt FSM
// WB_TRACE_PRINT_EN adds a result_file port, prints dequeued records and finishes on halt.
module writeback_retire
  import writeback_retire_pkg::*;
#(
  parameter int LANES       = 2,
  parameter int TRACE_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  MEM_WB_REG [LANES-1:0] wb_in_i,
  input  logic [LANES-1:0]      wb_valid_i,
  output logic                  stall_o,
  output logic [LANES-1:0]      gpr_we_o,
  output Vec5 [LANES-1:0]       gpr_waddr_o,
  output Vec32 [LANES-1:0]      gpr_wdata_o,
  output logic                  trace_valid_o,
  input  logic                  trace_ready_i,
  output TraceEntry             trace_entry_o,
  output Vec32                  retired_count_o,
  output logic                  halted_o
`ifdef WB_TRACE_PRINT_EN
  ,
  input  integer                result_file
`endif
);
  localparam int AW = $clog2(TRACE_DEPTH);
  WbState                state_q, state_d;
  Vec32                  count_q, count_d, seq;
  logic [AW:0]           occ;
  logic [LANES-1:0]      is_sys, alive, needs, enq, ret;
  logic [5:0]            need;
  logic                  accept, sys_ret, older_sys, unused_instr;
  TraceEntry [LANES-1:0] rec;
  // Everything younger than the oldest SYSCALL is squashed
  always_comb begin
    is_sys = '0;
    alive = '0;
    needs = '0;
    older_sys = 1'b0;
    unused_instr = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      is_sys[l] = wb_valid_i[l] && wb_in_i[l].controlSignal.instructionCode == SYSCALL;
      alive[l] = wb_valid_i[l] && !older_sys;
      needs[l] = alive[l] && wb_in_i[l].controlSignal.gprWriteEnabled && wb_in_i[l].gprWriteRegister != '0;
      older_sys = older_sys | is_sys[l];
      unused_instr = unused_instr ^ (^wb_in_i[l].instruction);
    end
  end
  // Free space is judged on start-of-cycle occupancy; a same-cycle dequeue earns no credit
  assign need    = ones(32'(needs));
  assign accept  = state_q == WB_RUN && 32'(TRACE_DEPTH) - 32'(occ) >= 32'(need);
  assign enq     = accept ? needs : '0;
  assign ret     = accept ? alive : '0;
  assign sys_ret = |(ret & is_sys);
  assign stall_o = !accept;
  always_comb begin
    gpr_we_o = enq;
    gpr_waddr_o = '0;
    gpr_wdata_o = '0;
    rec = '0;
    seq = count_q;
    for (int l = 0; l < LANES; l++) begin
      for (int k = l + 1; k < LANES; k++)
        if (enq[k] && wb_in_i[k].gprWriteRegister == wb_in_i[l].gprWriteRegister) gpr_we_o[l] = 1'b0;
      gpr_waddr_o[l] = wb_in_i[l].gprWriteRegister;
      gpr_wdata_o[l] = wb_in_i[l].gprWriteInput;
      rec[l] = '{pc: wb_in_i[l].pcValue, rd: wb_in_i[l].gprWriteRegister, data: wb_in_i[l].gprWriteInput, seq: seq};
      seq = seq + 32'(ret[l]);
    end
    count_d = seq;
  end
  always_comb
    state_d = state_q == WB_RUN   ? (sys_ret ? WB_DRAIN : WB_RUN) :
              state_q == WB_DRAIN ? (occ == '0 ? WB_HALTED : WB_DRAIN) : WB_HALTED;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WB_RUN;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end
  assign retired_count_o = count_q;
  assign halted_o        = state_q == WB_HALTED;
  wb_trace_fifo #(.LANES(LANES), .TRACE_DEPTH(TRACE_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .enq_i      (enq),
    .enq_data_i (rec),
    .deq_i      (trace_ready_i),
    .valid_o    (trace_valid_o),
    .head_o     (trace_entry_o),
    .occ_o      (occ)
  );
`ifdef WB_TRACE_PRINT_EN
  always_ff @(posedge clk) begin
    if (rst_n && trace_valid_o && trace_ready_i)
      $display("@%h: $%d <= %h", trace_entry_o.pc, trace_entry_o.rd, trace_entry_o.data);
    if (rst_n && state_q == WB_DRAIN && state_d == WB_HALTED) $finish;
  end
`endif
endmodule

// File: tb/tb_writeback_retire.sv
// tb_writeback_retire: randomized scoreboard bench for writeback_retire
// A program-order reference model predicts outputs and trace records; a monitor checks dequeues.
module tb_writeback_retire;
  import writeback_retire_pkg::*;
  localparam int LANES = 2;
  localparam int DEPTH = 8;
  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  MEM_WB_REG [LANES-1:0] wb_in;
  logic [LANES-1:0]      wb_valid;
  logic                  stall, trace_valid, trace_ready, halted;
  logic [LANES-1:0]      gpr_we;
  Vec5 [LANES-1:0]       gpr_waddr;
  Vec32 [LANES-1:0]      gpr_wdata;
  TraceEntry             trace_entry;
  Vec32                  retired_count;
  always #5 clk = ~clk;
  writeback_retire #(.LANES(LANES), .TRACE_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wb_in_i         (wb_in),
    .wb_valid_i      (wb_valid),
    .stall_o         (stall),
    .gpr_we_o        (gpr_we),
    .gpr_waddr_o     (gpr_waddr),
    .gpr_wdata_o     (gpr_wdata),
    .trace_valid_o   (trace_valid),
    .trace_ready_i   (trace_ready),
    .trace_entry_o   (trace_entry),
    .retired_count_o (retired_count),
    .halted_o        (halted)
`ifdef WB_TRACE_PRINT_EN
    ,
    .result_file     (32'h8000_0001)
`endif
  );
  int checks = 0;
  int passes = 0;
  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endfunction
  // Reference model: retires lanes in program order, one record per real register write
  typedef enum {M_RUN, M_DRAIN, M_HALT} mstate_t;
  mstate_t          m_state = M_RUN;
  int               m_occ = 0;
  int unsigned      m_count = 0;
  TraceEntry        exp_q[$];
  Vec32             model_gpr [32];
  Vec32             dut_gpr [32];
  logic [LANES-1:0] m_alive, m_writes;
  int               m_need;
  bit               m_acc, m_sys_seen, m_exp_we, m_deq, fin = 0, fin_done = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_occ = 0;
      m_count = 0;
      m_state = M_RUN;
      chk("rst_stall", stall, 0);
      chk("rst_trace_valid", trace_valid, 0);
      chk("rst_retired_count", retired_count, 0);
      chk("rst_halted", halted, 0);
      chk("rst_gpr_we", gpr_we, 0);
    end else begin
      if (fin && !fin_done) begin
        fin_done = 1;
        chk("scoreboard_leftover", exp_q.size(), 0);
        for (int r = 1; r < 32; r++) chk($sformatf("gpr_file_%0d", r), dut_gpr[r], model_gpr[r]);
      end
      m_sys_seen = 0;
      m_need = 0;
      for (int l = 0; l < LANES; l++) begin
        m_alive[l] = wb_valid[l] && !m_sys_seen;
        if (wb_valid[l] && wb_in[l].controlSignal.instructionCode == SYSCALL) m_sys_seen = 1;
        m_writes[l] = m_alive[l] && wb_in[l].controlSignal.gprWriteEnabled && wb_in[l].gprWriteRegister != 0;
        m_need += int'(m_writes[l]);
      end
      m_acc = m_state == M_RUN && DEPTH - m_occ >= m_need;
      chk("stall", stall, !m_acc);
      chk("trace_valid", trace_valid, m_occ != 0);
      chk("halted", halted, m_state == M_HALT);
      chk("retired_count", retired_count, m_count);
      for (int l = 0; l < LANES; l++) begin
        m_exp_we = m_acc && m_writes[l];
        for (int k = l + 1; k < LANES; k++)
          if (m_writes[k] && wb_in[k].gprWriteRegister == wb_in[l].gprWriteRegister) m_exp_we = 0;
        chk($sformatf("gpr_we_%0d", l), gpr_we[l], m_exp_we);
        if (gpr_we[l]) begin
          chk($sformatf("gpr_waddr_%0d", l), gpr_waddr[l], wb_in[l].gprWriteRegister);
          chk($sformatf("gpr_wdata_%0d", l), gpr_wdata[l], wb_in[l].gprWriteInput);
          dut_gpr[gpr_waddr[l]] = gpr_wdata[l];
        end
      end
      m_deq = m_occ != 0 && trace_ready;
      if (m_acc) begin
        for (int l = 0; l < LANES; l++) begin
          if (m_alive[l]) begin
            if (m_writes[l]) begin
              exp_q.push_back('{pc: wb_in[l].pcValue, rd: wb_in[l].gprWriteRegister, data: wb_in[l].gprWriteInput, seq: m_count});
              model_gpr[wb_in[l].gprWriteRegister] = wb_in[l].gprWriteInput;
              m_occ++;
            end
            if (wb_in[l].controlSignal.instructionCode == SYSCALL) m_state = M_DRAIN;
            m_count++;
          end
        end
      end else if (m_state == M_DRAIN && m_occ == 0) m_state = M_HALT;
      if (m_deq) m_occ--;
    end
  end
  TraceEntry mon_prev, mon_exp;
  bit        mon_hold = 0;
  always @(negedge clk) begin
    if (!rst_n) mon_hold = 0;
    else begin
      if (mon_hold && trace_valid) chk("trace_stable", trace_entry, mon_prev);
      if (trace_valid && trace_ready) begin
        if (exp_q.size() == 0) chk("trace_extra", trace_valid, 0);
        else begin
          mon_exp = exp_q.pop_front();
          chk("trace_entry", trace_entry, mon_exp);
        end
      end
      mon_hold = trace_valid && !trace_ready;
      mon_prev = trace_entry;
    end
  end
  bit   rnd = 0;
  Vec32 pc_ctr = 32'h0040_0000;
  task automatic set_lane(input int l, input bit v, input Vec5 r, input Vec32 d, input bit we, input InstructionCode ic);
    wb_valid[l] = v;
    wb_in[l].pcValue = pc_ctr;
    wb_in[l].instruction = $urandom;
    wb_in[l].controlSignal = '{instructionCode: ic, gprWriteEnabled: we};
    wb_in[l].gprWriteRegister = r;
    wb_in[l].gprWriteInput = d;
    pc_ctr += 4;
  endtask
  task automatic rand_pair();
    for (int l = 0; l < LANES; l++)
      set_lane(l, $urandom_range(0, 3) != 0,
               $urandom_range(0, 3) == 0 ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3)),
               $urandom, $urandom_range(0, 4) != 0, InstructionCode'($urandom_range(0, 4)));
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    if (rnd) trace_ready = $urandom_range(0, 3) != 0;
  endtask
  task automatic wait_accept();
    int t = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      if (++t > 300) begin
        $display("FAIL accept_timeout: stall=%0d after %0d cycles, expected 0", stall, t);
        $fatal(1, "accept timeout");
      end
      step();
    end
    step();
  endtask
  task automatic idle(input int n);
    wb_valid = '0;
    repeat (n) step();
  endtask
  initial begin
    int t;
    wb_in = '0;
    wb_valid = '0;
    trace_ready = 1'b1;
    for (int r = 0; r < 32; r++) begin
      model_gpr[r] = '0;
      dut_gpr[r] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    set_lane(0, 1, 5'd8, 32'h11, 1, IC_ALU);
    set_lane(1, 1, 5'd9, 32'h22, 1, IC_ALU);
    wait_accept();
    idle(3);
    set_lane(0, 1, 5'd8, 32'hA, 1, IC_ALU);
    set_lane(1, 1, 5'd8, 32'hB, 1, IC_LOAD);
    wait_accept();
    idle(3);
    set_lane(0, 1, 5'd0, 32'hFFFF, 1, IC_ALU);
    set_lane(1, 0, 5'd7, 32'h1, 1, IC_ALU);
    wait_accept();
    idle(2);
    trace_ready = 1'b0;
    for (int p = 0; p < 4; p++) begin
      set_lane(0, 1, 5'($urandom_range(1, 31)), $urandom, 1, IC_ALU);
      set_lane(1, 1, 5'($urandom_range(1, 31)), $urandom, 1, IC_ALU);
      wait_accept();
    end
    set_lane(0, 1, 5'd20, 32'h55, 1, IC_ALU);
    set_lane(1, 1, 5'd21, 32'h66, 1, IC_ALU);
    repeat (3) step();
    trace_ready = 1'b1;
    step();
    trace_ready = 1'b0;
    repeat (2) step();
    trace_ready = 1'b1;
    step();
    trace_ready = 1'b0;
    wait_accept();
    trace_ready = 1'b1;
    idle(12);
    rnd = 1;
    repeat (300) begin
      rand_pair();
      wait_accept();
    end
    rnd = 0;
    trace_ready = 1'b1;
    idle(12);
    set_lane(0, 1, 5'd0, 32'h0, 0, IC_SYSCALL);
    set_lane(1, 1, 5'd4, 32'h44, 1, IC_ALU);
    wait_accept();
    idle(6);
    rand_pair();
    repeat (5) step();
    idle(1);
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    idle(1);
    trace_ready = 1'b0;
    set_lane(0, 1, 5'd1, 32'h101, 1, IC_ALU);
    set_lane(1, 1, 5'd2, 32'h202, 1, IC_ALU);
    wait_accept();
    set_lane(0, 1, 5'd3, 32'h303, 1, IC_LOAD);
    set_lane(1, 0, 5'd0, 32'h0, 0, IC_NOP);
    wait_accept();
    set_lane(0, 1, 5'd0, 32'h0, 0, IC_SYSCALL);
    wait_accept();
    idle(1);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    trace_ready = 1'b1;
    idle(3);
    rnd = 1;
    repeat (60) begin
      rand_pair();
      wait_accept();
    end
    set_lane(0, 1, 5'd12, 32'hC0DE, 1, IC_ALU);
    set_lane(1, 1, 5'd0, 32'h0, 0, IC_SYSCALL);
    wait_accept();
    wb_valid = '0;
    t = 0;
    while (!halted) begin
      step();
      if (++t > 300) begin
        $display("FAIL halt_timeout: halted=%0d after %0d cycles, expected 1", halted, t);
        $fatal(1, "halt timeout");
      end
    end
    fin = 1;
    repeat (3) step();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
